// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline control blocks: opcode constants,
// the hazard scheduler state type and a small decode helper.
package core_pkg;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;

    // RUN: pipeline flows normally; MEM_WAIT: a data-memory access is outstanding.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    // Only R-type, store and branch instructions actually read rs2; for the
    // other formats bits [24:20] are immediate bits and must not create hazards.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Stops at all-ones instead of wrapping so long runs stay meaningful.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next value: clear wins, otherwise count up until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard scheduler for the 5-stage RV32I core. Combinationally
// decides stall/flush of the PC and pipeline registers from load-use hazards,
// EX-resolved redirects and the data-memory handshake; tracks a memory wait
// state with a sticky timeout flag and keeps stall/flush performance counters.
module hazard_ctrl_unit
    import core_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      inst_id_i,
    input  logic [31:0]      inst_ex_i,
    input  logic             MemRead_ex_i,
    input  logic             pc_sel_ex_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             stall_pc_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             state_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    hz_state_e         state_q;
    hz_state_e         state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              err_q;
    logic              err_d;

    logic [4:0] rd_ex;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic [6:0] opcode_id;
    logic       load_use;
    logic       redirect;
    logic       freeze;
    logic       stall_inc;
    logic       flush_inc;

    // Only register fields and the ID opcode matter for hazard detection.
    assign rd_ex     = inst_ex_i[11:7];
    assign rs1_id    = inst_id_i[19:15];
    assign rs2_id    = inst_id_i[24:20];
    assign opcode_id = inst_id_i[6:0];

    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_ex_i[31:12], inst_ex_i[6:0],
                                inst_id_i[31:25], inst_id_i[14:7]};

    // x0 is never a real destination, so a load to x0 cannot cause a hazard.
    assign load_use = MemRead_ex_i && (rd_ex != 5'd0) &&
                      ((rs1_id == rd_ex) ||
                       (uses_rs2(opcode_id) && (rs2_id == rd_ex)));

    assign redirect = pc_sel_ex_i;

    // The release cycle (ready high) is never frozen: the pipeline advances.
    assign freeze = ((state_q == RUN)      && dmem_req_i && !dmem_ready_i) ||
                    ((state_q == MEM_WAIT) && !dmem_ready_i);

    // Prioritised stall/flush decision; reset forces everything quiet.
    always_comb begin
        stall_pc_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        stall_mem_o = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!rst_i) begin
            if (freeze) begin
                // Whole pipeline holds; deferred hazards re-evaluate after release.
                stall_pc_o  = 1'b1;
                stall_id_o  = 1'b1;
                stall_ex_o  = 1'b1;
                stall_mem_o = 1'b1;
                stall_inc   = 1'b1;
            end else if (redirect) begin
                // ID holds a wrong-path instruction, so any load-use is moot.
                flush_id_o = 1'b1;
                flush_ex_o = 1'b1;
                flush_inc  = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, inject a bubble into EX for one cycle.
                stall_pc_o = 1'b1;
                stall_id_o = 1'b1;
                flush_ex_o = 1'b1;
                stall_inc  = 1'b1;
            end
        end
    end

    // Memory-wait state machine, wait counter and sticky timeout flag.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            RUN: begin
                if (dmem_req_i && !dmem_ready_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready_i) begin
                    state_d = RUN;
                end else begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                    // Timeout only flags the problem; the freeze carries on.
                    if (wait_cnt_d == WAIT_MAX) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign state_o = (state_q == MEM_WAIT);
    assign err_o   = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule
